logic_l2_arb: RTL
=================

LOGIC_L2_ARB -- requirements
Module: logic_l2_arb

Interface
REQ-001 SHALL have parameter PAR_DATA_BITS, default 8, accumulator/data width; even, >=2.
REQ-002 SHALL have parameter PAR_REQ_NUM, default 4, number of requesters; 2..8.
REQ-003 SHALL have parameter PAR_TIMEOUT, default 16, idle-beat limit in cycles; >=1.
REQ-004 SHALL have port ib_clk, input, 1, sole clock; all logic on rising edge.
REQ-005 SHALL have port ib_rst, input, 1, reset; synchronous, active-high.
REQ-006 SHALL have port ivG_req, input, PAR_REQ_NUM, per-requester job request.
REQ-007 SHALL have port ivG_valid, input, PAR_REQ_NUM, per-requester data-beat valid.
REQ-008 SHALL have port ivG_last, input, PAR_REQ_NUM, per-requester final-beat marker.
REQ-009 SHALL have port ivG_data, input, PAR_REQ_NUM*PAR_DATA_BITS; requester k owns slice [k*PAR_DATA_BITS +: PAR_DATA_BITS].
REQ-010 SHALL have port ovG_gnt, output, PAR_REQ_NUM, one-hot grant; doubles as beat ready.
REQ-011 SHALL have port ob_res_valid, output, 1, result available.
REQ-012 SHALL have port ib_res_ready, input, 1, result consumer ready.
REQ-013 SHALL have port ovG_res_data, output, PAR_DATA_BITS, folded result.
REQ-014 SHALL have port ovG_res_id, output, $clog2(PAR_REQ_NUM), index of job owner.
REQ-015 SHALL have port ob_res_err, output, 1, job aborted by timeout.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, RESP.
REQ-017 IDLE: if any ivG_req bit set, SHALL pick the first set bit at or after round-robin pointer (wrapping), clear the accumulator, and enter RUN next cycle with ovG_gnt one-hot on the winner.
REQ-018 IDLE with no request SHALL stay in IDLE with ovG_gnt=0.
REQ-019 RUN: a beat SHALL be accepted in each cycle where ovG_gnt[k] and ivG_valid[k] are both 1; accumulator <= accumulator + data slice k, modulo 2^PAR_DATA_BITS.
REQ-020 Valid/last/data of non-granted requesters SHALL be ignored; ivG_req deassertion during RUN SHALL be ignored.
REQ-021 On an accepted beat with ivG_last[k]=1, SHALL include that beat, drop ovG_gnt, and enter RESP next cycle.
REQ-022 RESP: ob_res_valid=1; ovG_res_data = S ^ {S[PAR_DATA_BITS/2-1:0], S[PAR_DATA_BITS-1:PAR_DATA_BITS/2]} (S = final sum); ovG_res_id = k; outputs stable until handshake.
REQ-023 RESP exits to IDLE in the cycle ob_res_valid & ib_res_ready; pointer SHALL then become (k+1) mod PAR_REQ_NUM.
REQ-024 A new arbitration SHALL NOT occur in the handshake cycle; earliest new grant is 2 cycles after handshake (IDLE decision, then RUN).
REQ-025 A single-beat job (valid & last on first granted cycle) SHALL produce ob_res_valid on the following cycle.
REQ-026 ovG_gnt SHALL never have more than one bit set; ovG_gnt=0 outside RUN.

Reset
REQ-027 ib_rst=1 at any clock edge, including mid-RUN or mid-RESP, SHALL force IDLE, pointer=0, accumulator=0, timeout counter=0, discarding any job.
REQ-028 During and one cycle after reset: ovG_gnt=0, ob_res_valid=0, ovG_res_data=0, ovG_res_id=0, ob_res_err=0.

Configuration
REQ-029 Macro LOGIC_L2_ARB_TIMEOUT_EN SHALL gate the beat watchdog.
REQ-030 Defined: counter clears on grant and each accepted beat, increments each RUN cycle without a beat; reaching PAR_TIMEOUT SHALL drop grant, enter RESP with ob_res_err=1 and partial-sum result; ob_res_err=0 for normal completion.
REQ-031 Undefined: no counter logic; ob_res_err tied 0; RUN waits indefinitely; PAR_TIMEOUT unused.

Verification
REQ-032 Defaults, req[2]=1 only, beats 0x10,0x22,0x03(last) -> S=0x35, ovG_res_data=0x35^0x53=0x66, ovG_res_id=2, err=0.
REQ-033 All four req held, pointer 0, single-beat 0x01 jobs -> grants in order 0,1,2,3,0; no two grants overlap.
REQ-034 Sum wrap: beats 0xF0,0x20(last) -> S=0x10, ovG_res_data=0x11.
REQ-035 ib_res_ready held 0 for 5 cycles in RESP -> ob_res_valid, data, id stable; no new grant until 2 cycles after ready=1.
REQ-036 ib_rst pulsed mid-RUN after 2 beats -> all outputs 0 next cycle; next job from requester 0 sums from 0.
REQ-037 With LOGIC_L2_ARB_TIMEOUT_EN, PAR_TIMEOUT=4, one beat 0x05 then valid=0 -> RESP after 4 idle cycles, ob_res_err=1, ovG_res_data=0x55.

Source files
------------

// File: rtl/logic_l2_arb.sv
// Round-robin job arbiter: grants one requester, sums its beats, returns a half-swapped fold of the sum.
// Optional beat watchdog is compiled in when LOGIC_L2_ARB_TIMEOUT_EN is defined.
module logic_l2_arb #(
    parameter int PAR_DATA_BITS = 8,
    parameter int PAR_REQ_NUM   = 4,
    parameter int PAR_TIMEOUT   = 16
) (
    input  logic                                   ib_clk,
    input  logic                                   ib_rst,
    input  logic [PAR_REQ_NUM-1:0]                 ivG_req,
    input  logic [PAR_REQ_NUM-1:0]                 ivG_valid,
    input  logic [PAR_REQ_NUM-1:0]                 ivG_last,
    input  logic [PAR_REQ_NUM*PAR_DATA_BITS-1:0]   ivG_data,
    output logic [PAR_REQ_NUM-1:0]                 ovG_gnt,
    output logic                                   ob_res_valid,
    input  logic                                   ib_res_ready,
    output logic [PAR_DATA_BITS-1:0]               ovG_res_data,
    output logic [$clog2(PAR_REQ_NUM)-1:0]         ovG_res_id,
    output logic                                   ob_res_err
);
    localparam int ID_W = $clog2(PAR_REQ_NUM);
    localparam int HALF = PAR_DATA_BITS / 2;

    typedef enum logic [1:0] {IDLE, RUN, RESP} state_t;
    state_t state, state_nxt;

    logic [ID_W-1:0]          ptr, owner, winner;
    logic [ID_W-1:0]          cand [PAR_REQ_NUM];
    logic [PAR_DATA_BITS-1:0] lane [PAR_REQ_NUM];
    logic [PAR_DATA_BITS-1:0] acc;
    logic                     found, beat, done, tmo;

    // cand[i] is the requester i positions after the pointer, wrapping
    for (genvar k = 0; k < PAR_REQ_NUM; k++) begin : g_lane
        assign lane[k] = ivG_data[k*PAR_DATA_BITS +: PAR_DATA_BITS];
        assign cand[k] = ID_W'((int'(ptr) + k) % PAR_REQ_NUM);
    end

    // Scan from the far end so the closest set request wins
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int i = PAR_REQ_NUM - 1; i >= 0; i--) begin
            if (ivG_req[cand[i]]) begin
                winner = cand[i];
                found  = 1'b1;
            end
        end
    end

    assign beat = (state == RUN) && ivG_valid[owner];
    assign done = beat && ivG_last[owner];

`ifdef LOGIC_L2_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(PAR_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PAR_TIMEOUT - 1);

    logic [CNT_W-1:0] cnt;
    logic             err;

    assign tmo = (state == RUN) && !beat && (cnt == CNT_LAST);

    always_ff @(posedge ib_clk) begin
        if (ib_rst) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            if (state != RUN || beat)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
            if (state == IDLE)
                err <= 1'b0;
            else if (tmo)
                err <= 1'b1;
        end
    end

    assign ob_res_err = ob_res_valid && err;
`else
    assign tmo        = 1'b0;
    assign ob_res_err = 1'b0;
`endif

    always_ff @(posedge ib_clk) begin
        if (ib_rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (found) state_nxt = RUN;
            RUN:     if (done || tmo) state_nxt = RESP;
            RESP:    if (ib_res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ib_clk) begin
        if (ib_rst) begin
            ptr   <= '0;
            owner <= '0;
            acc   <= '0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    owner <= winner;
                    acc   <= '0;
                end
                RUN:  if (beat) acc <= acc + lane[owner];
                RESP: if (ib_res_ready)
                    ptr <= (owner == ID_W'(PAR_REQ_NUM - 1)) ? '0 : owner + 1'b1;
                default: ;
            endcase
        end
    end

    // Outputs are masked by reset so they read zero in the reset cycle itself
    always_comb begin
        ovG_gnt = '0;
        if (state == RUN && !ib_rst)
            ovG_gnt[owner] = 1'b1;
    end

    assign ob_res_valid = (state == RESP) && !ib_rst;
    assign ovG_res_data = ob_res_valid ? (acc ^ {acc[HALF-1:0], acc[PAR_DATA_BITS-1:HALF]}) : '0;
    assign ovG_res_id   = ob_res_valid ? owner : '0;

endmodule
